// File: rtl/hcsr04_emulator.sv
// HC-SR04 responder: validates the trig pulse width, then after a burst delay
// answers with an echo whose width encodes distance_mm (100 MHz timebase).
module hcsr04_emulator #(
  parameter int unsigned MIN_TRIG_CYC   = 1000,
  parameter int unsigned ECHO_DELAY_CYC = 20000,
  parameter int unsigned MAX_MM         = 4000,
  parameter int unsigned TIMEOUT_CYC    = 3800000,
  parameter int unsigned HOLDOFF_CYC    = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        trig,
  input  logic [11:0] distance_mm,
  output logic        echo,
  output logic        busy,
  output logic        done,
  output logic        trig_err,
  output logic        ign_trig
);

  localparam int unsigned TW = $clog2(MIN_TRIG_CYC + 1);
  localparam logic [TW-1:0] T_MIN    = TW'(MIN_TRIG_CYC);
  localparam logic [22:0]   DLY_LAST = 23'(ECHO_DELAY_CYC - 1);
  localparam logic [22:0]   TO_LAST  = 23'(TIMEOUT_CYC - 1);
  localparam logic [22:0]   HO_LAST  = 23'(HOLDOFF_CYC - 1);
  localparam logic [11:0]   MAX_D    = 12'(MAX_MM);
  localparam logic [13:0]   ACC_STEP = 14'd17;
  localparam logic [13:0]   ACC_WRAP = 14'd10000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG_HI,
    S_ARM,
    S_ECHO,
    S_HOLDOFF
  } state_t;

  state_t        r_state;
  logic          r_sync1;
  logic          r_trig_s;
  logic          r_trig_d;
  logic [TW-1:0] r_t_cnt;
  logic [22:0]   r_cnt;
  logic [13:0]   r_acc;
  logic [11:0]   r_d_cnt;
  logic [11:0]   r_d_lat;
  logic          r_no_tgt;
  logic          r_echo;
  logic          r_busy;
  logic          r_done;
  logic          r_trig_err;
  logic          r_ign;

  logic          w_trig_rise;
  logic [13:0]   w_acc_sum;
  logic          w_acc_wrap;
  logic [13:0]   w_acc_next;
  logic [11:0]   w_d_next;

  assign w_trig_rise = r_trig_s & ~r_trig_d;
  assign w_acc_sum   = r_acc + ACC_STEP;
  assign w_acc_wrap  = (w_acc_sum >= ACC_WRAP);
  assign w_acc_next  = w_acc_wrap ? (w_acc_sum - ACC_WRAP) : w_acc_sum;
  assign w_d_next    = r_d_cnt + {11'd0, w_acc_wrap};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_sync1    <= 1'b0;
      r_trig_s   <= 1'b0;
      r_trig_d   <= 1'b0;
      r_t_cnt    <= '0;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_d_cnt    <= '0;
      r_d_lat    <= '0;
      r_no_tgt   <= 1'b0;
      r_echo     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_trig_err <= 1'b0;
      r_ign      <= 1'b0;
    end else begin
      r_sync1    <= trig;
      r_trig_s   <= r_sync1;
      r_trig_d   <= r_trig_s;
      r_done     <= 1'b0;
      r_trig_err <= 1'b0;
      r_ign      <= 1'b0;

      if (!enable) begin
        r_state <= S_IDLE;
        r_echo  <= 1'b0;
        r_busy  <= 1'b0;
        r_t_cnt <= '0;
        r_cnt   <= '0;
        r_acc   <= '0;
        r_d_cnt <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_trig_rise) begin
              r_state <= S_TRIG_HI;
              r_t_cnt <= TW'(1);
              r_busy  <= 1'b1;
            end
          end

          S_TRIG_HI: begin
            if (r_trig_s) begin
              if (r_t_cnt != T_MIN) r_t_cnt <= r_t_cnt + TW'(1);
            end else if (r_t_cnt >= T_MIN) begin
              r_d_lat  <= distance_mm;
              r_no_tgt <= (distance_mm == '0) || (distance_mm > MAX_D);
              r_d_cnt  <= '0;
              r_acc    <= '0;
              r_cnt    <= '0;
              r_t_cnt  <= '0;
              r_state  <= S_ARM;
            end else begin
              r_trig_err <= 1'b1;
              r_t_cnt    <= '0;
              r_busy     <= 1'b0;
              r_state    <= S_IDLE;
            end
          end

          S_ARM: begin
            r_ign <= w_trig_rise;
            if (r_cnt == DLY_LAST) begin
              r_cnt   <= '0;
              r_echo  <= 1'b1;
              r_state <= S_ECHO;
            end else begin
              r_cnt <= r_cnt + 23'd1;
            end
          end

          S_ECHO: begin
            r_ign <= w_trig_rise;
            // Fall is registered in the same cycle the 17/10000 accumulator
            // carries d_cnt up to d_lat, giving width ceil(d*10000/17).
            if (r_no_tgt) begin
              if (r_cnt == TO_LAST) begin
                r_cnt   <= '0;
                r_echo  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= S_HOLDOFF;
              end else begin
                r_cnt <= r_cnt + 23'd1;
              end
            end else begin
              r_acc   <= w_acc_next;
              r_d_cnt <= w_d_next;
              if (w_d_next == r_d_lat) begin
                r_cnt   <= '0;
                r_echo  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= S_HOLDOFF;
              end
            end
          end

          S_HOLDOFF: begin
            r_ign <= w_trig_rise;
            if (r_cnt == HO_LAST) begin
              r_cnt   <= '0;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_cnt <= r_cnt + 23'd1;
            end
          end

          default: begin
            r_state <= S_IDLE;
            r_echo  <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign echo     = r_echo;
  assign busy     = r_busy;
  assign done     = r_done;
  assign trig_err = r_trig_err;
  assign ign_trig = r_ign;

endmodule

// File: tb/tb_hcsr04_emulator.sv
// Directed bench for hcsr04_emulator with shortened timing parameters.
module tb_hcsr04_emulator;

  localparam int unsigned MIN_T = 10;
  localparam int unsigned DLY   = 50;
  localparam int unsigned MAXD  = 3;
  localparam int unsigned TO    = 2000;
  localparam int unsigned HO    = 300;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic        trig = 1'b0;
  logic [11:0] distance_mm = '0;
  logic        echo, busy, done, trig_err, ign_trig;

  int unsigned vecs = 0;
  int unsigned fails = 0;

  int unsigned cyc = 0;
  logic        echo_q = 1'b0;
  int unsigned rise_cyc = 0;
  int unsigned last_w = 0;
  int unsigned n_rise = 0;
  int unsigned n_done = 0;
  int unsigned n_err = 0;
  int unsigned n_ign = 0;

  always #5 clk = ~clk;

  hcsr04_emulator #(
    .MIN_TRIG_CYC  (MIN_T),
    .ECHO_DELAY_CYC(DLY),
    .MAX_MM        (MAXD),
    .TIMEOUT_CYC   (TO),
    .HOLDOFF_CYC   (HO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .trig       (trig),
    .distance_mm(distance_mm),
    .echo       (echo),
    .busy       (busy),
    .done       (done),
    .trig_err   (trig_err),
    .ign_trig   (ign_trig)
  );

  // Event monitor: echo width in cycles and pulse counters.
  always @(negedge clk) begin
    cyc    <= cyc + 1;
    echo_q <= echo;
    if (echo && !echo_q) begin
      rise_cyc <= cyc;
      n_rise   <= n_rise + 1;
    end
    if (!echo && echo_q) last_w <= cyc - rise_cyc;
    if (done)     n_done <= n_done + 1;
    if (trig_err) n_err  <= n_err + 1;
    if (ign_trig) n_ign  <= n_ign + 1;
  end

  task automatic pulse_trig(input int unsigned w);
    @(negedge clk);
    trig = 1'b1;
    repeat (w) @(negedge clk);
    trig = 1'b0;
  endtask

  task automatic wait_echo(input logic val, input int unsigned bound, output bit ok);
    ok = 1'b0;
    for (int unsigned i = 0; i < bound; i++) begin
      if (echo === val) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int unsigned i = 0; i < HO + 100; i++) begin
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_echo(input logic [11:0] d, output int unsigned w, output bit ok);
    bit ok1, ok2, ok3;
    distance_mm = d;
    pulse_trig(MIN_T);
    wait_echo(1'b1, DLY + 20, ok1);
    wait_echo(1'b0, TO + 2000, ok2);
    @(negedge clk);
    w = last_w;
    wait_idle(ok3);
    ok = ok1 & ok2 & ok3;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vecs++;
    if ({echo, busy, done, trig_err, ign_trig} !== 5'b0) begin
      fails++;
      $display("FAIL reset_outputs: got %b expected 00000", {echo, busy, done, trig_err, ign_trig});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_first_echo;
    int unsigned lat, d0, e0;
    bit seen, ok;
    d0 = n_done;
    e0 = n_err;
    distance_mm = 12'd1;
    pulse_trig(MIN_T);
    lat = 0;
    seen = 1'b0;
    for (int unsigned i = 0; i < DLY + 20; i++) begin
      @(negedge clk);
      lat++;
      if (echo === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    vecs++;
    if (!seen || lat != DLY + 3) begin
      fails++;
      $display("FAIL echo_latency: got %0d (seen=%0b) expected %0d", lat, seen, DLY + 3);
    end
    wait_echo(1'b0, TO + 2000, ok);
    @(negedge clk);
    vecs++;
    if (!ok || last_w != 589) begin
      fails++;
      $display("FAIL width_d1: got %0d (ok=%0b) expected 589", last_w, ok);
    end
    vecs++;
    if (last_w * 17 / 10000 != 1) begin
      fails++;
      $display("FAIL recover_d1: got %0d expected 1", last_w * 17 / 10000);
    end
    vecs++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL busy_holdoff: got %b expected 1", busy);
    end
    wait_idle(ok);
    vecs++;
    if (!ok || n_done - d0 != 1) begin
      fails++;
      $display("FAIL done_once: got %0d (idle=%0b) expected 1", n_done - d0, ok);
    end
    vecs++;
    if (n_err - e0 != 0) begin
      fails++;
      $display("FAIL no_trig_err: got %0d expected 0", n_err - e0);
    end
  endtask

  task automatic test_widths;
    int unsigned w;
    bit ok;
    run_echo(12'd3, w, ok);
    vecs++;
    if (!ok || w != 1765) begin
      fails++;
      $display("FAIL width_dmax: got %0d (ok=%0b) expected 1765", w, ok);
    end
    vecs++;
    if (w * 17 / 10000 != 3) begin
      fails++;
      $display("FAIL recover_dmax: got %0d expected 3", w * 17 / 10000);
    end
    run_echo(12'd0, w, ok);
    vecs++;
    if (!ok || w != TO) begin
      fails++;
      $display("FAIL width_d0: got %0d (ok=%0b) expected %0d", w, ok, TO);
    end
    run_echo(12'd4, w, ok);
    vecs++;
    if (!ok || w != TO) begin
      fails++;
      $display("FAIL width_over_max: got %0d (ok=%0b) expected %0d", w, ok, TO);
    end
  endtask

  task automatic test_short_trig;
    int unsigned e0, r0, w;
    bit ok;
    e0 = n_err;
    r0 = n_rise;
    distance_mm = 12'd1;
    pulse_trig(MIN_T - 1);
    repeat (DLY + 20) @(negedge clk);
    vecs++;
    if (n_err - e0 != 1) begin
      fails++;
      $display("FAIL short_trig_err: got %0d expected 1", n_err - e0);
    end
    vecs++;
    if (n_rise != r0 || echo !== 1'b0) begin
      fails++;
      $display("FAIL short_no_echo: got %0d rises expected 0", n_rise - r0);
    end
    vecs++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL short_busy: got %b expected 0", busy);
    end
    run_echo(12'd1, w, ok);
    vecs++;
    if (!ok || w != 589) begin
      fails++;
      $display("FAIL after_short_width: got %0d (ok=%0b) expected 589", w, ok);
    end
  endtask

  task automatic test_back_to_back;
    int unsigned i0, r0, w;
    bit ok1, ok2, ok3;
    i0 = n_ign;
    r0 = n_rise;
    distance_mm = 12'd2;
    pulse_trig(MIN_T);
    wait_echo(1'b1, DLY + 20, ok1);
    repeat (100) @(negedge clk);
    pulse_trig(MIN_T);
    wait_echo(1'b0, TO + 2000, ok2);
    @(negedge clk);
    w = last_w;
    repeat (20) @(negedge clk);
    pulse_trig(MIN_T);
    wait_idle(ok3);
    repeat (DLY + 50) @(negedge clk);
    vecs++;
    if (!(ok1 & ok2 & ok3) || w != 1177) begin
      fails++;
      $display("FAIL ignored_width: got %0d (ok=%0b%0b%0b) expected 1177", w, ok1, ok2, ok3);
    end
    vecs++;
    if (n_ign - i0 != 2) begin
      fails++;
      $display("FAIL ign_count: got %0d expected 2", n_ign - i0);
    end
    vecs++;
    if (n_rise - r0 != 1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL no_second_echo: got %0d rises busy=%b expected 1 rise busy=0", n_rise - r0, busy);
    end
    run_echo(12'd1, w, ok1);
    vecs++;
    if (!ok1 || w != 589) begin
      fails++;
      $display("FAIL after_holdoff_width: got %0d (ok=%0b) expected 589", w, ok1);
    end
  endtask

  task automatic test_mid_rst;
    bit ok;
    distance_mm = 12'd3;
    pulse_trig(MIN_T);
    wait_echo(1'b1, DLY + 20, ok);
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vecs++;
    if (!ok || {echo, busy, done, trig_err, ign_trig} !== 5'b0) begin
      fails++;
      $display("FAIL mid_rst: got %b (ok=%0b) expected 00000", {echo, busy, done, trig_err, ign_trig}, ok);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_mid_enable;
    int unsigned d0;
    bit ok;
    d0 = n_done;
    distance_mm = 12'd3;
    pulse_trig(MIN_T);
    wait_echo(1'b1, DLY + 20, ok);
    repeat (100) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    vecs++;
    if (!ok || echo !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL mid_enable: got echo=%b busy=%b (ok=%0b) expected 0 0", echo, busy, ok);
    end
    repeat (5) @(negedge clk);
    vecs++;
    if (n_done != d0) begin
      fails++;
      $display("FAIL enable_no_done: got %0d expected 0", n_done - d0);
    end
    enable = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_distance_change;
    bit ok1, ok2, ok3;
    distance_mm = 12'd2;
    pulse_trig(MIN_T);
    wait_echo(1'b1, DLY + 20, ok1);
    repeat (50) @(negedge clk);
    distance_mm = 12'd3;
    wait_echo(1'b0, TO + 2000, ok2);
    @(negedge clk);
    vecs++;
    if (!(ok1 & ok2) || last_w != 1177) begin
      fails++;
      $display("FAIL dist_change_width: got %0d (ok=%0b%0b) expected 1177", last_w, ok1, ok2);
    end
    wait_idle(ok3);
    vecs++;
    if (!ok3) begin
      fails++;
      $display("FAIL dist_change_idle: got busy=%b expected 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_first_echo();
    test_widths();
    test_short_trig();
    test_back_to_back();
    test_mid_rst();
    test_mid_enable();
    test_distance_change();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
